fifo_rd_unpacker: RTL and testbench

FIFO_RD_UNPACKER -- requirements
Module: fifo_rd_unpacker

---
 rtl/fifo_rd_pkg.sv | 14 +
 rtl/fifo_rd_line_cnt.sv | 57 +++++
 rtl/fifo_rd_unpacker.sv | 125 ++++++++++++
 tb/tb_fifo_rd_unpacker.sv | 237 +++++++++++++++++++++++
 4 files changed

// File: rtl/fifo_rd_pkg.sv
// rtl/fifo_rd_pkg.sv - shared state encoding and width helper for the FIFO read unpacker
package fifo_rd_pkg;

    typedef enum logic {
        ST_EMPTY = 1'b0,
        ST_FULL  = 1'b1
    } rd_state_e;

    // Counter/index width that never collapses to zero bits for a range of one.
    function automatic int cnt_w(input int n);
        return (n <= 1) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/fifo_rd_line_cnt.sv
// rtl/fifo_rd_line_cnt.sv - beat/line counters producing start/end-of-line and start-of-frame markers
module fifo_rd_line_cnt
    import fifo_rd_pkg::*;
#(
    parameter int LINE_BEATS  = 1920,
    parameter int FRAME_LINES = 1080
) (
    input  logic rd_clk,
    input  logic rd_rst,
    input  logic sync_clr_i,
    input  logic beat_i,
    output logic sol_o,
    output logic eol_o,
    output logic sof_o
);

    localparam int BW = cnt_w(LINE_BEATS);
    localparam int LW = cnt_w(FRAME_LINES);

    logic [BW-1:0] beat_q, beat_d;
    logic [LW-1:0] line_q, line_d;
    logic          last_beat, last_line;

    assign last_beat = (beat_q == BW'(LINE_BEATS - 1));
    assign last_line = (line_q == LW'(FRAME_LINES - 1));

    always_ff @(posedge rd_clk or posedge rd_rst) begin
        if (rd_rst) begin
            beat_q <= '0;
            line_q <= '0;
        end else begin
            beat_q <= beat_d;
            line_q <= line_d;
        end
    end

    always_comb begin
        beat_d = beat_q;
        line_d = line_q;
        if (sync_clr_i) begin
            beat_d = '0;
            line_d = '0;
        end else if (beat_i) begin
            if (last_beat) begin
                beat_d = '0;
                line_d = last_line ? '0 : line_q + LW'(1);
            end else begin
                beat_d = beat_q + BW'(1);
            end
        end
    end

    assign sol_o = (beat_q == '0);
    assign eol_o = last_beat;
    assign sof_o = (beat_q == '0) && (line_q == '0);

endmodule

// File: rtl/fifo_rd_unpacker.sv
// rtl/fifo_rd_unpacker.sv - pops wide FIFO words and emits them as OUT_W slices, LSB first
// Optional line/frame markers under FIFO_RD_UNPACKER_MARKER_EN.
module fifo_rd_unpacker
    import fifo_rd_pkg::*;
#(
    parameter int IN_W        = 32,
    parameter int OUT_W       = 8,
    parameter int LINE_BEATS  = 1920,
    parameter int FRAME_LINES = 1080
) (
    input  logic             rd_clk,
    input  logic             rd_rst,
    input  logic             sync_clr,
    input  logic [IN_W-1:0]  fifo_data,
    input  logic             fifo_vld,
    output logic             fifo_rd_en,
    output logic [OUT_W-1:0] out_data,
    output logic             out_valid,
    input  logic             out_ready
`ifdef FIFO_RD_UNPACKER_MARKER_EN
    ,
    output logic             out_sol,
    output logic             out_eol,
    output logic             out_sof
`endif
);

    localparam int R     = IN_W / OUT_W;
    localparam int IDX_W = cnt_w(R);

    rd_state_e                state_q, state_d;
    logic [IN_W-1:0]          hold_q, hold_d;
    logic [IDX_W-1:0]         idx_q, idx_d;
    logic                     hold_vld, last_slice, pop, beat;
    logic [R-1:0][OUT_W-1:0]  slices;

    assign hold_vld   = (state_q == ST_FULL);
    assign last_slice = (idx_q == IDX_W'(R - 1));
    assign beat       = hold_vld & out_ready;
    assign pop        = fifo_vld & fifo_rd_en;
    assign slices     = hold_q;

    always_ff @(posedge rd_clk or posedge rd_rst) begin
        if (rd_rst) begin
            state_q <= ST_EMPTY;
        end else begin
            state_q <= state_d;
        end
    end

    always_ff @(posedge rd_clk or posedge rd_rst) begin
        if (rd_rst) begin
            hold_q <= '0;
            idx_q  <= '0;
        end else begin
            hold_q <= hold_d;
            idx_q  <= idx_d;
        end
    end

    // A pop always wins over the last-slice beat, which gives the bubble-free reload.
    always_comb begin
        state_d = state_q;
        hold_d  = hold_q;
        idx_d   = idx_q;
        if (sync_clr) begin
            state_d = ST_EMPTY;
            hold_d  = '0;
            idx_d   = '0;
        end else begin
            case (state_q)
                ST_EMPTY: begin
                    if (pop) begin
                        state_d = ST_FULL;
                        hold_d  = fifo_data;
                        idx_d   = '0;
                    end
                end
                ST_FULL: begin
                    if (pop) begin
                        hold_d = fifo_data;
                        idx_d  = '0;
                    end else if (beat) begin
                        if (last_slice) begin
                            state_d = ST_EMPTY;
                            idx_d   = '0;
                        end else begin
                            idx_d = idx_q + IDX_W'(1);
                        end
                    end
                end
                default: state_d = ST_EMPTY;
            endcase
        end
    end

    always_comb begin
        fifo_rd_en = fifo_vld & ~sync_clr & ~rd_rst &
                     (~hold_vld | (last_slice & out_ready));
        out_valid  = hold_vld;
        out_data   = slices[idx_q];
    end

`ifdef FIFO_RD_UNPACKER_MARKER_EN
    logic sol, eol, sof;

    fifo_rd_line_cnt #(
        .LINE_BEATS  (LINE_BEATS),
        .FRAME_LINES (FRAME_LINES)
    ) u_line_cnt (
        .rd_clk     (rd_clk),
        .rd_rst     (rd_rst),
        .sync_clr_i (sync_clr),
        .beat_i     (beat),
        .sol_o      (sol),
        .eol_o      (eol),
        .sof_o      (sof)
    );

    assign out_sol = hold_vld & sol;
    assign out_eol = hold_vld & eol;
    assign out_sof = hold_vld & sof;
`endif

endmodule

// File: tb/tb_fifo_rd_unpacker.sv
// tb/tb_fifo_rd_unpacker.sv - self-checking bench for fifo_rd_unpacker with a queue-based reference model
module tb_fifo_rd_unpacker;

    logic        rd_clk = 1'b0;
    logic        rd_rst = 1'b1;
    logic        sync_clr = 1'b0;
    logic [31:0] fifo_data = '0;
    logic        fifo_vld = 1'b0;
    logic        out_ready = 1'b0;
    logic        fifo_rd_en;
    logic [7:0]  out_data;
    logic        out_valid;
`ifdef FIFO_RD_UNPACKER_MARKER_EN
    logic        out_sol, out_eol, out_sof;
`endif

    int checks = 0;
    int passes = 0;

    fifo_rd_unpacker #(
        .IN_W        (32),
        .OUT_W       (8),
        .LINE_BEATS  (8),
        .FRAME_LINES (2)
    ) dut (
        .rd_clk     (rd_clk),
        .rd_rst     (rd_rst),
        .sync_clr   (sync_clr),
        .fifo_data  (fifo_data),
        .fifo_vld   (fifo_vld),
        .fifo_rd_en (fifo_rd_en),
        .out_data   (out_data),
        .out_valid  (out_valid),
        .out_ready  (out_ready)
`ifdef FIFO_RD_UNPACKER_MARKER_EN
        ,
        .out_sol    (out_sol),
        .out_eol    (out_eol),
        .out_sof    (out_sof)
`endif
    );

    always #5 rd_clk = ~rd_clk;

    task automatic tick();
        @(posedge rd_clk);
        #1;
    endtask

    task automatic drive(input logic vld, input logic [31:0] data, input logic rdy);
        fifo_vld  = vld;
        fifo_data = data;
        out_ready = rdy;
        #1;
    endtask

    task automatic cleanup();
        sync_clr = 1'b1;
        drive(1'b0, 32'h0, 1'b0);
        tick();
        sync_clr = 1'b0;
        #1;
    endtask

    task automatic test_reset();
        rd_rst = 1'b1;
        drive(1'b1, 32'hdeadbeef, 1'b1);
        tick();
        tick();
        checks++; if (out_valid !== 1'b0) $display("FAIL reset_out_valid got=%0b exp=0", out_valid); else passes++;
        checks++; if (out_data !== 8'h00) $display("FAIL reset_out_data got=%h exp=00", out_data); else passes++;
        checks++; if (fifo_rd_en !== 1'b0) $display("FAIL reset_rd_en got=%0b exp=0", fifo_rd_en); else passes++;
        rd_rst = 1'b0;
        drive(1'b0, 32'h0, 1'b0);
    endtask

    task automatic test_single_word();
        logic [31:0] w;
        w = 32'h44332211;
        cleanup();
        drive(1'b1, w, 1'b1);
        checks++; if (out_valid !== 1'b0) $display("FAIL single_pre_valid got=%0b exp=0", out_valid); else passes++;
        checks++; if (fifo_rd_en !== 1'b1) $display("FAIL single_pop got=%0b exp=1", fifo_rd_en); else passes++;
        tick();
        drive(1'b0, 32'h0, 1'b1);
        for (int i = 0; i < 4; i++) begin
            checks++; if (out_valid !== 1'b1) $display("FAIL single_valid[%0d] got=%0b exp=1", i, out_valid); else passes++;
            checks++; if (out_data !== 8'(w >> (8 * i))) $display("FAIL single_data[%0d] got=%h exp=%h", i, out_data, 8'(w >> (8 * i))); else passes++;
            tick();
        end
        checks++; if (out_valid !== 1'b0) $display("FAIL single_empty got=%0b exp=0", out_valid); else passes++;
    endtask

    task automatic test_stream();
        logic [31:0] words [6];
        logic [31:0] w;
        cleanup();
        for (int i = 0; i < 6; i++) words[i] = $urandom;
        for (int k = 0; k < 20; k++) begin
            drive(1'b1, words[k / 4], 1'b1);
            checks++; if (fifo_rd_en !== ((k % 4) == 0)) $display("FAIL stream_rd_en[%0d] got=%0b exp=%0b", k, fifo_rd_en, (k % 4) == 0); else passes++;
            checks++; if (out_valid !== (k >= 1)) $display("FAIL stream_valid[%0d] got=%0b exp=%0b", k, out_valid, k >= 1); else passes++;
            if (k >= 1) begin
                w = words[(k - 1) / 4];
                checks++; if (out_data !== 8'(w >> (8 * ((k - 1) % 4)))) $display("FAIL stream_data[%0d] got=%h exp=%h", k, out_data, 8'(w >> (8 * ((k - 1) % 4)))); else passes++;
            end
            tick();
        end
    endtask

    task automatic test_stall();
        logic [31:0] w2;
        w2 = $urandom;
        cleanup();
        drive(1'b1, 32'h44332211, 1'b1);
        tick();
        drive(1'b1, w2, 1'b1);
        tick();
        tick();
        drive(1'b1, w2, 1'b0);
        for (int i = 0; i < 5; i++) begin
            checks++; if (out_data !== 8'h33) $display("FAIL stall_data[%0d] got=%h exp=33", i, out_data); else passes++;
            checks++; if (out_valid !== 1'b1) $display("FAIL stall_valid[%0d] got=%0b exp=1", i, out_valid); else passes++;
            checks++; if (fifo_rd_en !== 1'b0) $display("FAIL stall_rd_en[%0d] got=%0b exp=0", i, fifo_rd_en); else passes++;
            tick();
        end
        drive(1'b1, w2, 1'b1);
        checks++; if (out_data !== 8'h33) $display("FAIL stall_resume got=%h exp=33", out_data); else passes++;
        tick();
        checks++; if (out_data !== 8'h44) $display("FAIL stall_last got=%h exp=44", out_data); else passes++;
        checks++; if (fifo_rd_en !== 1'b1) $display("FAIL stall_reload got=%0b exp=1", fifo_rd_en); else passes++;
        tick();
        checks++; if (out_data !== w2[7:0]) $display("FAIL stall_next got=%h exp=%h", out_data, w2[7:0]); else passes++;
    endtask

    task automatic test_clear(input int use_rst);
        logic [31:0] w, w2;
        w  = $urandom;
        w2 = $urandom;
        cleanup();
        drive(1'b1, w, 1'b1);
        tick();
        drive(1'b0, 32'h0, 1'b1);
        tick();
        checks++; if (out_data !== w[15:8]) $display("FAIL clear%0d_idx1 got=%h exp=%h", use_rst, out_data, w[15:8]); else passes++;
        if (use_rst != 0) rd_rst = 1'b1; else sync_clr = 1'b1;
        drive(1'b1, w2, 1'b1);
        checks++; if (fifo_rd_en !== 1'b0) $display("FAIL clear%0d_rd_en got=%0b exp=0", use_rst, fifo_rd_en); else passes++;
        tick();
        rd_rst   = 1'b0;
        sync_clr = 1'b0;
        drive(1'b0, 32'h0, 1'b1);
        checks++; if (out_valid !== 1'b0) $display("FAIL clear%0d_valid got=%0b exp=0", use_rst, out_valid); else passes++;
        drive(1'b1, w2, 1'b1);
        checks++; if (fifo_rd_en !== 1'b1) $display("FAIL clear%0d_pop got=%0b exp=1", use_rst, fifo_rd_en); else passes++;
        tick();
        drive(1'b0, 32'h0, 1'b1);
        checks++; if (out_data !== w2[7:0]) $display("FAIL clear%0d_slice0 got=%h exp=%h", use_rst, out_data, w2[7:0]); else passes++;
    endtask

    task automatic test_random();
        logic [7:0]  exp_q [$];
        logic [31:0] next_w;
        logic        vld, rdy, clr, exp_rd;
        int          pend;
        cleanup();
        next_w = $urandom;
        for (int c = 0; c < 400; c++) begin
            vld = ($urandom_range(0, 3) != 0);
            rdy = ($urandom_range(0, 3) != 0);
            clr = ($urandom_range(0, 31) == 0);
            sync_clr = clr;
            drive(vld, next_w, rdy);
            pend   = exp_q.size();
            exp_rd = vld && !clr && (pend == 0 || (pend == 1 && rdy));
            checks++; if (fifo_rd_en !== exp_rd) $display("FAIL rand_rd_en[%0d] got=%0b exp=%0b", c, fifo_rd_en, exp_rd); else passes++;
            checks++; if (out_valid !== (pend > 0)) $display("FAIL rand_valid[%0d] got=%0b exp=%0b", c, out_valid, pend > 0); else passes++;
            if (pend > 0) begin
                checks++; if (out_data !== exp_q[0]) $display("FAIL rand_data[%0d] got=%h exp=%h", c, out_data, exp_q[0]); else passes++;
            end
            if (clr) begin
                exp_q.delete();
            end else begin
                if (pend > 0 && rdy) void'(exp_q.pop_front());
                if (exp_rd) begin
                    for (int s = 0; s < 4; s++) exp_q.push_back(8'(next_w >> (8 * s)));
                    next_w = $urandom;
                end
            end
            tick();
        end
        sync_clr = 1'b0;
    endtask

`ifdef FIFO_RD_UNPACKER_MARKER_EN
    task automatic test_markers();
        int b;
        b = 0;
        cleanup();
        for (int c = 0; c < 40 && b < 20; c++) begin
            drive(1'b1, $urandom, 1'b1);
            if (out_valid && out_ready) begin
                checks++; if (out_sol !== ((b % 8) == 0)) $display("FAIL mark_sol[%0d] got=%0b exp=%0b", b, out_sol, (b % 8) == 0); else passes++;
                checks++; if (out_eol !== ((b % 8) == 7)) $display("FAIL mark_eol[%0d] got=%0b exp=%0b", b, out_eol, (b % 8) == 7); else passes++;
                checks++; if (out_sof !== ((b % 16) == 0)) $display("FAIL mark_sof[%0d] got=%0b exp=%0b", b, out_sof, (b % 16) == 0); else passes++;
                b++;
            end else begin
                checks++; if ({out_sol, out_eol, out_sof} !== 3'b000) $display("FAIL mark_idle got=%b exp=000", {out_sol, out_eol, out_sof}); else passes++;
            end
            tick();
        end
        checks++; if (b !== 20) $display("FAIL mark_beats got=%0d exp=20", b); else passes++;
    endtask
`endif

    initial begin
        #200000;
        $display("FAIL timeout got=running exp=finished");
        $fatal(1, "bench timeout");
    end

    initial begin
        test_reset();
        test_single_word();
        test_stream();
        test_stall();
        test_clear(0);
        test_clear(1);
        test_random();
`ifdef FIFO_RD_UNPACKER_MARKER_EN
        test_markers();
`endif
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
